// File: rtl/writeback_queue.sv
// writeback_queue
//
// In-order write-back buffer in front of the single write port of the
// 64-bit, 32-entry register file. Completed results are accepted over a
// valid/ready handshake, held in a circular FIFO, and drained one per cycle
// into the register file. Two bypass read ports let decode see the newest
// pending value of any register that has not been committed yet.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears all pending state
//   in_valid       result offered this cycle
//   in_ready       queue can accept (not full, reset low)
//   in_reg         destination register of offered result
//   in_data        value of offered result
//   hold           suppresses draining this cycle
//   RegWrite       register-file write enable
//   WriteRegister  register-file write address (head entry, 0 when empty)
//   WriteData      register-file write data (head entry, 0 when empty)
//   rd1_reg/rd2_reg    registers being read by decode
//   rd1_hit/rd2_hit    a pending entry targets rdN_reg
//   rd1_data/rd2_data  newest pending value for rdN_reg, 0 when no hit
//   count          number of pending entries

module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_reg,
    input  logic [63:0]                in_data,
    input  logic                       hold,
    output logic                       RegWrite,
    output logic [4:0]                 WriteRegister,
    output logic [63:0]                WriteData,
    input  logic [4:0]                 rd1_reg,
    input  logic [4:0]                 rd2_reg,
    output logic                       rd1_hit,
    output logic                       rd2_hit,
    output logic [63:0]                rd1_data,
    output logic [63:0]                rd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]    reg_mem  [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on registered occupancy (plus reset), so a producer
    // can never create a combinational loop through in_valid.
    assign in_ready = !reset && !full;
    assign accept   = in_valid && in_ready;

    // Register 31 is hardwired zero: the handshake completes but nothing is
    // stored, so it never reaches the register file or the bypass search.
    assign push = accept && (in_reg != 5'd31);

    assign RegWrite      = !empty && !hold;
    assign pop           = RegWrite;
    assign WriteRegister = empty ? 5'd0  : reg_mem[head];
    assign WriteData     = empty ? 64'd0 : data_mem[head];

    // Walk the valid entries from oldest to youngest; a later match
    // overwrites an earlier one, so the result is the entry nearest the tail.
    function automatic logic [64:0] lookup(input logic [4:0] rd);
        logic [64:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rd != 5'd31) && (reg_mem[idx] == rd)) begin
                res = {1'b1, data_mem[idx]};
            end
        end
        return res;
    endfunction

    assign {rd1_hit, rd1_data} = lookup(rd1_reg);
    assign {rd2_hit, rd2_data} = lookup(rd2_reg);

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because
    // DEPTH is a power of two. Simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: the bypass search and the write port
    // only ever look at entries covered by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            reg_mem[tail]  <= in_reg;
            data_mem[tail] <= in_data;
        end
    end

endmodule
